// File: rtl/rr_grant_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_grant_arbiter
// Purpose  : Round-robin arbiter sharing one resource among N requesters, with
//            grant hold, back-to-back handover and optional tenure timeout.
// Revision : 1.0
// ============================================================================
module rr_grant_arbiter #(
  parameter  int unsigned N        = 8,
  parameter  int unsigned HOLD_MAX = 16,
  localparam int unsigned IDX_W    = (N > 1) ? $clog2(N) : 1,
  localparam int unsigned CNT_W    = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic [N-1:0]     req_i,
  input  logic             done_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_val_o,
  output logic             timeout_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT   = (HOLD_MAX != 0) ? CNT_W'(HOLD_MAX) : CNT_W'(1);
  localparam logic [IDX_W-1:0] PTR_RST   = IDX_W'(N - 1);

  state_e           state_q;
  logic [N-1:0]     gnt_q;
  logic [IDX_W-1:0] idx_q;
  logic             val_q;
  logic             timeout_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] ptr_q;

  logic [IDX_W-1:0] base_idx;
  logic             hi_any;
  logic [IDX_W-1:0] hi_idx;
  logic             lo_any;
  logic [IDX_W-1:0] lo_idx;
  logic             win_any;
  logic [IDX_W-1:0] win_idx;
  logic [N-1:0]     win_onehot;
  logic             owner_req;
  logic             at_limit;
  logic             rel;
  logic             to_pulse;

  // While busy the current owner is the rotation base, so a handover on the
  // release edge already skips past it.
  always_comb begin
    base_idx = (state_q == ST_BUSY) ? idx_q : ptr_q;
    hi_any   = 1'b0;
    hi_idx   = '0;
    lo_any   = 1'b0;
    lo_idx   = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (req_i[k]) begin
        lo_any = 1'b1;
        lo_idx = IDX_W'(k);
        if (k > int'(base_idx)) begin
          hi_any = 1'b1;
          hi_idx = IDX_W'(k);
        end
      end
    end
    win_any = lo_any;
    win_idx = hi_any ? hi_idx : lo_idx;
  end

  for (genvar g = 0; g < N; g++) begin : g_onehot
    assign win_onehot[g] = (win_idx == IDX_W'(g));
  end

  assign owner_req = |(req_i & gnt_q);
  assign at_limit  = (HOLD_MAX != 0) && (cnt_q == CNT_LIMIT);
  assign rel       = done_i | ~owner_req | at_limit;
  assign to_pulse  = at_limit & ~done_i & owner_req;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      idx_q     <= '0;
      val_q     <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
      ptr_q     <= PTR_RST;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (win_any) begin
            state_q <= ST_BUSY;
            gnt_q   <= win_onehot;
            idx_q   <= win_idx;
            val_q   <= 1'b1;
            cnt_q   <= CNT_W'(1);
          end
        end
        ST_BUSY: begin
          if (!rel) begin
            if (cnt_q != CNT_SAT) begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else begin
            ptr_q     <= idx_q;
            timeout_q <= to_pulse;
            if (win_any) begin
              gnt_q <= win_onehot;
              idx_q <= win_idx;
              val_q <= 1'b1;
              cnt_q <= CNT_W'(1);
            end else begin
              state_q <= ST_IDLE;
              gnt_q   <= '0;
              idx_q   <= '0;
              val_q   <= 1'b0;
              cnt_q   <= '0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt_q   <= '0;
          idx_q   <= '0;
          val_q   <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_idx_o = idx_q;
  assign gnt_val_o = val_q;
  assign timeout_o = timeout_q;

  a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (!arst_n_i) $onehot0(gnt_o));
  a_gnt_val     : assert property (@(posedge clk_i) disable iff (!arst_n_i) gnt_val_o == (|gnt_o));

endmodule
`default_nettype wire
